// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: D = A - B, one bit per clock, LSB first.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bo_q, bo_d;

    logic             d_bit;
    logic             bout;
    logic [WIDTH-1:0] r_shift;

    // Single subtractor cell working on the operand LSBs.
    assign d_bit = a_q[0] ^ b_q[0] ^ borrow_q;
    assign bout  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

    always_comb begin
        r_shift            = r_q >> 1;
        r_shift[WIDTH-1]   = d_bit;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        bo_d     = bo_q;
        case (state_q)
            S_SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                r_d      = r_shift;
                borrow_d = bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    dout_d  = r_shift;
                    bo_d    = bout;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request, giving back-to-back operation.
                if (start) begin
                    state_d  = S_SHIFT;
                    a_d      = A;
                    b_d      = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            dout_q   <= '0;
            bo_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            bo_q     <= bo_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign D    = dout_q;
    assign Bo   = bo_q;

endmodule
